// File: rtl/mem_dma_copy.sv
// mem_dma_copy: block copy engine that borrows the shared 16-bit byte-addressed memory port via bus_req/bus_gnt.
// Optional fill mode (constant byte writes) is built only when DMA_FILL_EN is defined.
module mem_dma_copy #(
    parameter int ALLOW_WIDE = 1,
    parameter int HOLD_BUS   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] cfg_src,
    input  logic [15:0] cfg_dst,
    input  logic [15:0] cfg_len,
    input  logic        cfg_fill,
    input  logic [7:0]  cfg_fill_val,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        m_en,
    output logic        m_wr,
    output logic        m_wide,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_FIN
    } state_t;

    state_t      state_q;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [15:0] rem_q;
    logic [15:0] data_q;
    logic [15:0] addr_hold_q;
    logic [15:0] wdata_hold_q;
    logic        wide_q;

    logic        fill_q;
    logic [7:0]  fill_val_q;
    logic        start_fill;

    logic        in_rd;
    logic        in_wr;
    logic        acc_cycle;
    logic        acc_wide;
    logic        xfer_wide;
    logic [15:0] step;
    logic [15:0] rem_next;
    logic [15:0] wr_data;

`ifdef DMA_FILL_EN
    assign start_fill = cfg_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q     <= 1'b0;
            fill_val_q <= 8'h00;
        end else if (state_q == S_IDLE && start && !abort) begin
            fill_q     <= cfg_fill;
            fill_val_q <= cfg_fill_val;
        end
    end
`else
    logic unused_fill;

    assign start_fill  = 1'b0;
    assign fill_q      = 1'b0;
    assign fill_val_q  = 8'h00;
    assign unused_fill = ^{cfg_fill, cfg_fill_val};
`endif

    // Port strobes follow bus_gnt in the same cycle, so they are decoded from state, not registered.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_rd     = (state_q == S_RD);
        in_wr     = (state_q == S_WR);
        acc_cycle = (in_rd || in_wr) && bus_gnt;
        acc_wide  = (ALLOW_WIDE != 0) && (rem_q >= 16'd2);
        // Copy writes reuse the width picked at read time; fill writes pick it on the spot.
        xfer_wide = (in_rd || fill_q) ? acc_wide : wide_q;
        step      = xfer_wide ? 16'd2 : 16'd1;
        rem_next  = rem_q - step;
        wr_data   = fill_q ? {fill_val_q, fill_val_q} : data_q;

        m_en      = acc_cycle;
        m_wr      = acc_cycle && in_wr;
        m_wide    = acc_cycle && xfer_wide;
        m_addr    = acc_cycle ? (in_rd ? src_q : dst_q) : addr_hold_q;
        m_wdata   = (acc_cycle && in_wr) ? wr_data : wdata_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= 16'h0000;
            dst_q        <= 16'h0000;
            rem_q        <= 16'h0000;
            data_q       <= 16'h0000;
            addr_hold_q  <= 16'h0000;
            wdata_hold_q <= 16'h0000;
            wide_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus_req      <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            done <= 1'b0;

            // Address and write data hold their last driven values while the port is not granted.
            if (acc_cycle) begin
                addr_hold_q <= m_addr;
            end
            if (acc_cycle && in_wr) begin
                wdata_hold_q <= m_wdata;
            end

            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy    <= 1'b0;
                bus_req <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            src_q <= cfg_src;
                            dst_q <= cfg_dst;
                            rem_q <= cfg_len;
                            if (cfg_len == 16'h0000) begin
                                state_q <= S_FIN;
                                done    <= 1'b1;
                            end else begin
                                state_q <= start_fill ? S_WR : S_RD;
                                busy    <= 1'b1;
                                bus_req <= 1'b1;
                            end
                        end
                    end

                    S_RD: begin
                        if (bus_gnt) begin
                            wide_q  <= acc_wide;
                            state_q <= S_CAP;
                            bus_req <= (HOLD_BUS != 0);
                        end
                    end

                    S_CAP: begin
                        // Byte reads arrive on the upper lane; realign so byte writes find them on [7:0].
                        data_q  <= wide_q ? m_rdata : {8'h00, m_rdata[15:8]};
                        state_q <= S_WR;
                        bus_req <= 1'b1;
                    end

                    S_WR: begin
                        if (bus_gnt) begin
                            src_q <= src_q + step;
                            dst_q <= dst_q + step;
                            rem_q <= rem_next;
                            if (rem_next == 16'h0000) begin
                                state_q <= S_FIN;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                bus_req <= 1'b0;
                            end else begin
                                state_q <= fill_q ? S_WR : S_RD;
                                bus_req <= 1'b1;
                            end
                        end
                    end

                    S_FIN: begin
                        state_q <= S_IDLE;
                    end

                    default: begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                        bus_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_dma_copy.sv
// Self-checking bench for mem_dma_copy: byte-array memory, per-transfer expectation queue, randomized jobs.
// Fill-mode jobs are exercised only when DMA_FILL_EN is defined.
module tb_mem_dma_copy;

    localparam int ALLOW_WIDE = 1;
    localparam int HOLD_BUS   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_src = 16'h0;
    logic [15:0] cfg_dst = 16'h0;
    logic [15:0] cfg_len = 16'h0;
    logic        cfg_fill = 1'b0;
    logic [7:0]  cfg_fill_val = 8'h0;
    logic        bus_gnt = 1'b0;
    logic [15:0] m_rdata = 16'h0;
    logic        busy, done, bus_req, m_en, m_wr, m_wide;
    logic [15:0] m_addr, m_wdata;

    int checks = 0;
    int errors = 0;

    mem_dma_copy #(.ALLOW_WIDE(ALLOW_WIDE), .HOLD_BUS(HOLD_BUS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
        .cfg_fill(cfg_fill), .cfg_fill_val(cfg_fill_val),
        .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .m_en(m_en), .m_wr(m_wr), .m_wide(m_wide), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: 64 KiB of bytes, big-endian wide lanes, read data one cycle after the enable cycle.
    logic [7:0]  mem [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0;
    logic [7:0]  poke_data = 8'h0;

    initial begin
        logic [15:0] a1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        forever begin
            @(posedge clk);
            if (poke_en) mem[poke_addr] = poke_data;
            if (rst_n && m_en) begin
                a1 = m_addr + 16'd1;
                if (m_wr) begin
                    if (m_wide) begin
                        mem[m_addr] = m_wdata[15:8];
                        mem[a1]     = m_wdata[7:0];
                    end else begin
                        mem[m_addr] = m_wdata[7:0];
                    end
                end else begin
                    m_rdata <= m_wide ? {mem[m_addr], mem[a1]} : {mem[m_addr], 8'($urandom)};
                end
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Grant patterns: 0 = always granted, 1 = repeating 1-0-0-1, 2 = random.
    int gnt_mode = 0;
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            case (gnt_mode)
                0:       bus_gnt = 1'b1;
                1:       begin bus_gnt = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
                default: bus_gnt = 1'($urandom_range(0, 1));
            endcase
        end
    end

    typedef struct {
        logic        wr;
        logic        wide;
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } acc_t;

    acc_t exp_q[$];
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;

    // Compare process: every port access must be the next expected transfer; busy/done follow job boundaries.
    always @(negedge clk) begin
        acc_t e;
        logic last_wr;
        if (!rst_n) begin
            exp_q.delete();
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            last_wr = 1'b0;
            if (m_en) begin
                check("en_needs_gnt", bus_gnt, 1);
                check("en_needs_req", bus_req, 1);
                check("access_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("acc_addr", m_addr, e.addr);
                    check("acc_wr", m_wr, e.wr);
                    check("acc_wide", m_wide, e.wide);
                    if (e.wr) check("acc_wdata", e.wide ? m_wdata : {8'h00, m_wdata[7:0]}, e.data);
                    last_wr = e.last;
                end
            end else begin
                check("wr_without_en", m_wr, 0);
            end
            if (!busy) check("req_while_idle", bus_req, 0);

            exp_done = last_wr && !abort;
            if (last_wr) exp_busy = 1'b0;
            if (start && !busy && !done && !abort) begin
                if (cfg_len == 16'h0) exp_done = 1'b1;
                else                  exp_busy = 1'b1;
            end
            if (abort && busy) begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
                exp_q.delete();
            end
        end
    end

    // Plans the expected transfer list from the byte-count rules, runs the job, then checks memory.
    task automatic run_job(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                           input logic fill, input logic [7:0] fv,
                           input int abort_at, input int rst_at, output int cyc);
        logic [7:0]  src_b[$];
        logic [7:0]  pre_b[$];
        logic [7:0]  before_lo, before_hi;
        logic [15:0] s, d, r;
        int          n, k;
        bit          ended;
        for (int i = 0; i < int'(len); i++) begin
            src_b.push_back(fill ? fv : mem[16'(src + 16'(i))]);
            pre_b.push_back(mem[16'(dst + 16'(i))]);
        end
        before_lo = mem[16'(dst - 16'd1)];
        before_hi = mem[16'(dst + len)];
        s = src; d = dst; r = len; k = 0;
        while (r != 16'h0) begin
            n = (ALLOW_WIDE != 0 && r >= 16'd2) ? 2 : 1;
            if (!fill) exp_q.push_back('{1'b0, n == 2, s, 16'h0, 1'b0});
            exp_q.push_back('{1'b1, n == 2, d,
                              (n == 2) ? {src_b[k], src_b[k + 1]} : {8'h00, src_b[k]},
                              r == 16'(n)});
            s += 16'(n); d += 16'(n); r -= 16'(n); k += n;
        end

        @(posedge clk); #1;
        cfg_src = src; cfg_dst = dst; cfg_len = len; cfg_fill = fill; cfg_fill_val = fv;
        start = 1'b1;
        cyc = 0; ended = 0;
        while (!ended && cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            abort = (cyc == abort_at);
            if (cyc == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_req", bus_req, 0);
                check("rst_en", m_en, 0);
                check("rst_wr", m_wr, 0);
                check("rst_wide", m_wide, 0);
                check("rst_addr", m_addr, 0);
                check("rst_wdata", m_wdata, 0);
                ended = 1;
            end else begin
                @(negedge clk);
                if (done || (abort_at > 0 && cyc >= abort_at + 6)) ended = 1;
            end
        end
        abort = 1'b0;
        check("job_ends_in_budget", 32'(ended), 1);
        if (rst_at > 0) begin
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end else if (abort_at > 0) begin
            for (int i = 0; i < int'(len); i++)
                check("abort_dst_untouched", mem[16'(dst + 16'(i))], pre_b[i]);
        end else begin
            check("queue_drained", exp_q.size(), 0);
            for (int i = 0; i < int'(len); i++)
                check("dst_byte", mem[16'(dst + 16'(i))], src_b[i]);
            check("below_dst_untouched", mem[16'(dst - 16'd1)], before_lo);
            check("above_dst_untouched", mem[16'(dst + len)], before_hi);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int cyc;
        logic [15:0] rs, rd, rl;
        #2;
        check("reset_busy", busy, 0);
        check("reset_req", bus_req, 0);
        check("reset_en", m_en, 0);
        check("reset_addr", m_addr, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic copy with continuous grant: two wide reads/writes, done 7 cycles after start.
        poke(16'h1000, 8'h11); poke(16'h1001, 8'h22);
        poke(16'h1002, 8'h33); poke(16'h1003, 8'h44);
        gnt_mode = 0;
        run_job(16'h1000, 16'h2000, 16'd4, 1'b0, 8'h00, 0, 0, cyc);
        check("basic_done_latency", cyc, 7);
        check("basic_m2000", mem[16'h2000], 8'h11);
        check("basic_m2001", mem[16'h2001], 8'h22);
        check("basic_m2002", mem[16'h2002], 8'h33);
        check("basic_m2003", mem[16'h2003], 8'h44);

        // Odd length at odd addresses: wide then byte.
        run_job(16'h1001, 16'h3003, 16'd3, 1'b0, 8'h00, 0, 0, cyc);
        check("odd_done_latency", cyc, 7);
        check("odd_m3005", mem[16'h3005], mem[16'h1003]);

        // Grant stalls with the 1-0-0-1 pattern.
        gnt_mode = 1;
        run_job(16'h1200, 16'h2200, 16'd6, 1'b0, 8'h00, 0, 0, cyc);
        gnt_mode = 0;

        // Zero length: done the cycle after start, no access.
        run_job(16'h1300, 16'h2300, 16'd0, 1'b0, 8'h00, 0, 0, cyc);
        check("len0_done_latency", cyc, 1);

        // Source wraps through 0xFFFF to 0x0000.
        poke(16'hFFFE, 8'hDE); poke(16'hFFFF, 8'hAD);
        poke(16'h0000, 8'hBE); poke(16'h0001, 8'hEF);
        run_job(16'hFFFE, 16'h5000, 16'd4, 1'b0, 8'h00, 0, 0, cyc);
        check("wrap_m5000", mem[16'h5000], 8'hDE);
        check("wrap_m5001", mem[16'h5001], 8'hAD);
        check("wrap_m5002", mem[16'h5002], 8'hBE);
        check("wrap_m5003", mem[16'h5003], 8'hEF);

        // Abort during capture (cycle 2 with continuous grant).
        run_job(16'h1000, 16'h6000, 16'd4, 1'b0, 8'h00, 2, 0, cyc);
        check("abort_idle_after", busy, 0);

        // Reset pulled during the first write (cycle 3).
        run_job(16'h1100, 16'h6100, 16'd6, 1'b0, 8'h00, 0, 3, cyc);
        run_job(16'h1000, 16'h6200, 16'd2, 1'b0, 8'h00, 0, 0, cyc);
        check("post_reset_latency", cyc, 4);

`ifdef DMA_FILL_EN
        run_job(16'h0000, 16'h4000, 16'd5, 1'b1, 8'hA5, 0, 0, cyc);
        check("fill_done_latency", cyc, 4);
        check("fill_m4000", mem[16'h4000], 8'hA5);
        check("fill_m4004", mem[16'h4004], 8'hA5);
`endif

        // Random non-overlapping jobs under random grant patterns.
        for (int j = 0; j < 16; j++) begin
            rs = 16'($urandom);
            rd = rs + 16'h4000 + 16'($urandom_range(0, 255));
            rl = 16'($urandom_range(0, 9));
            gnt_mode = int'($urandom_range(0, 2));
`ifdef DMA_FILL_EN
            run_job(rs, rd, rl, 1'($urandom_range(0, 1)), 8'($urandom), 0, 0, cyc);
`else
            run_job(rs, rd, rl, 1'b0, 8'h00, 0, 0, cyc);
`endif
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_dma_copy.md
Name: mem_dma_copy

Overview:
- Bus initiator for the 16-bit byte-addressable synchronous memory port (en/wr/wide/addr/din/dout).
- Copies a byte block from src to dst without CPU involvement. Optional fill mode writes a constant byte instead.
- Shares the memory port with the CPU through a req/gnt handshake. The top level muxes the port to the engine while bus_gnt=1.

Parameters:
- ALLOW_WIDE, 1: 1 = 16-bit transfers while remaining >= 2; 0 = byte-only transfers.
- HOLD_BUS, 0: 1 = bus_req held from start to done; 0 = bus_req asserted only in RD/WR states.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_* when idle
- abort  in  1  synchronous cancel of the current operation
- cfg_src  in  16  source byte address
- cfg_dst  in  16  destination byte address
- cfg_len  in  16  byte count
- cfg_fill  in  1  fill mode (DMA_FILL_EN builds only)
- cfg_fill_val  in  8  fill byte (DMA_FILL_EN builds only)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse on normal completion
- bus_req  out  1  request for the memory port
- bus_gnt  in  1  port granted this cycle
- m_en  out  1  memory enable
- m_wr  out  1  memory write strobe
- m_wide  out  1  16-bit access
- m_addr  out  16  byte address, any alignment
- m_wdata  out  16  write data to memory din
- m_rdata  in  16  memory dout

Behaviour:
- Bus conventions (big-endian):
  - Wide access: bits[15:8] = M[addr], bits[7:0] = M[addr+1].
  - Byte read data is on m_rdata[15:8].
  - Byte write data is taken from m_wdata[7:0].
  - Read data is valid in the cycle after the m_en cycle.
- Reset: state IDLE; busy, done, bus_req, m_en, m_wr, m_wide = 0; m_addr, m_wdata = 0; internal src/dst/rem/data registers = 0.
- States: IDLE, RD, CAP, WR, FIN.
- IDLE:
  - start=1 latches src/dst/rem from cfg_*.
  - rem=0 -> FIN. Otherwise -> RD, or -> WR directly in fill mode.
  - start while busy is ignored.
- RD:
  - bus_req=1. m_en asserts only when bus_gnt=1, with m_wr=0, m_addr=src, m_wide=(ALLOW_WIDE && rem>=2).
  - Stays in RD until granted, then -> CAP.
- CAP:
  - No bus access. Captures m_rdata into data reg unconditionally; byte reads are shifted from [15:8] to [7:0].
  - -> WR.
- WR:
  - bus_req=1. On bus_gnt: m_en=1, m_wr=1, m_addr=dst, m_wide as chosen in RD, m_wdata=data (fill: {val,val}).
  - On the granted cycle: src+=n, dst+=n, rem-=n, where n=2 wide / 1 byte.
  - New rem=0 -> FIN, else -> RD (fill: stays WR).
- FIN: done=1 for one cycle, busy=0 next cycle -> IDLE.
- busy = 1 in RD, CAP and WR.
- Outputs while bus_gnt=0:
  - m_en = m_wr = 0.
  - m_addr and m_wdata hold their last values.
  - m_wide is a don't-care.
- Addresses wrap modulo 2^16: src=0xFFFF wide reads 0xFFFF then 0x0000.
- Odd length with ALLOW_WIDE=1: wide transfers first, final single byte last.
- Wide transfers at odd addresses are legal (memory handles misalignment).
- Throughput: 3 cycles per transfer (RD, CAP, WR) with continuous grant; fill mode 1 cycle per transfer.
- bus_gnt dropping between RD and WR is safe: the captured data is held in the data reg.
- Overlapping src/dst: forward copy only, no overlap correction.
- abort:
  - Taking effect in any non-IDLE state -> IDLE next cycle, with no done pulse.
  - A write issued in the same cycle completes normally.
  - abort has priority over start.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronous); the transfer is lost.

Optional Feature:
- Macro: DMA_FILL_EN.
- Defined:
  - cfg_fill/cfg_fill_val are functional.
  - With cfg_fill=1, src is ignored, RD/CAP are skipped, and each WR writes the fill byte (wide = {val,val}).
- Undefined:
  - Fill logic is not built and cfg_fill/cfg_fill_val are ignored.
  - The engine always copies.

Test Plan:
- Basic copy: M[0x1000..0x1003]=11 22 33 44, src=0x1000, dst=0x2000, len=4, gnt=1 -> 2 wide reads + 2 wide writes; M[0x2000..3]=11 22 33 44; done 7 cycles after start.
- Odd length and odd alignment: src=0x1001, dst=0x3003, len=3 -> wide then byte transfer; M[0x3003..5] equals the source bytes; M[0x3002] and M[0x3006] untouched.
- Grant stalls: toggle bus_gnt 1-0-0-1 during a len=6 copy -> m_en never asserts with gnt=0; the destination data is correct.
- len=0 and wrap: len=0 -> done the cycle after start with no m_en. Copy src=0xFFFE, len=4 -> reads 0xFFFE, 0x0000; destination correct.
- abort and reset: abort asserted in CAP -> busy=0 next cycle, no done pulse, no further writes. rst_n pulled low mid-WR -> all outputs 0 immediately.
- DMA_FILL_EN build: fill val=0xA5, dst=0x4000, len=5 -> M[0x4000..4]=A5; 3 write cycles; no reads.
